if_fetch_stage: RTL and testbench
=================================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 The parameter ADDR_W SHALL default to 6 and SHALL set the PC and instruction-memory address width.
REQ-002 The parameter DATA_W SHALL default to 16 and SHALL set the instruction width.
REQ-003 The parameter NOP_WORD SHALL default to 16'h0000 and SHALL be the bubble word driven on instr_out when no valid instruction is present.
REQ-004 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-005 The ports SHALL be as follows:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- pc_in  input  ADDR_W  fetch address from the PC stage.
- hold_in  input  1  stall request; 1 = hold the IF/ID contents.
- flush_in  input  1  flush request; 1 = squash the IF/ID contents.
- start  input  1  single-cycle command pulse.
- prog_we  input  1  program-load write enable.
- prog_addr  input  ADDR_W  program-load address.
- prog_data  input  DATA_W  program-load word.
- instr_out  output  DATA_W  IF/ID instruction.
- pc_next_out  output  ADDR_W  IF/ID copy of pc_in+1.
- valid_out  output  1  1 = instr_out holds a real instruction.
- state_out  output  2  FSM state: 00 IDLE, 01 RUN, 10 HALT.

Function
REQ-006 The block SHALL contain a 2^ADDR_W x DATA_W instruction memory that is not cleared by reset.
REQ-007 A write to mem[prog_addr] <= prog_data SHALL occur on a rising clk edge only when prog_we=1 and state=IDLE; prog_we SHALL be ignored in RUN and HALT.
REQ-008 The FSM SHALL leave IDLE for RUN on the first edge with start=1.
REQ-009 In RUN, start SHALL be ignored.
REQ-010 The FSM SHALL go from RUN to HALT on the edge that loads a word with [15:12]=4'hF into IF/ID.
REQ-011 In HALT, start=1 SHALL return the FSM to IDLE on the next edge.
REQ-012 In RUN, with hold_in=0 and flush_in=0, each edge SHALL load instr_out<=mem[pc_in], pc_next_out<=pc_in+1 and valid_out<=1, giving a latency of one cycle from pc_in to instr_out.
REQ-013 pc_next_out SHALL wrap modulo 2^ADDR_W, so pc_in=63 gives 0.
REQ-014 flush_in=1 SHALL, on the next edge in any state, set instr_out<=NOP_WORD, valid_out<=0 and pc_next_out<=0.
REQ-015 In RUN, the flushed cycle SHALL not fetch.
REQ-016 hold_in=1 with flush_in=0 SHALL keep instr_out, pc_next_out and valid_out unchanged.
REQ-017 When hold_in=1 on the edge that would load the halt word, the RUN-to-HALT transition SHALL be deferred.
REQ-018 When flush_in and hold_in are both 1 on the same edge, flush_in SHALL take priority.
REQ-019 A flushed halt word SHALL not cause the RUN-to-HALT transition.
REQ-020 In IDLE and HALT, the IF/ID register SHALL load a bubble (NOP_WORD, valid_out=0, pc_next_out=0) each edge unless hold_in=1.
REQ-021 The halt word itself SHALL be presented with valid_out=1 for one cycle, after which HALT loads bubbles.
REQ-022 state_out SHALL reflect the registered FSM state with no combinational path from inputs.

Reset
REQ-023 When rst_n=0, the block SHALL asynchronously set state=IDLE, instr_out=NOP_WORD, pc_next_out=0 and valid_out=0.
REQ-024 Memory contents SHALL be retained across reset.
REQ-025 Reset asserted during RUN SHALL abort fetching immediately, and after release the block SHALL wait in IDLE for start.
REQ-026 The block SHALL require no synchronous cleanup after reset release.

Verification
REQ-027 Load-and-run: write mem[5]=16'h1234 and mem[1]=16'h0A0B in IDLE, pulse start, drive pc_in=5 -> next edge instr_out=16'h1234, pc_next_out=6, valid_out=1.
REQ-028 Hold/flush priority: in RUN with pc_in=1, hold_in=1 for 2 cycles -> outputs frozen; then hold_in=1 and flush_in=1 -> instr_out=16'h0000, valid_out=0.
REQ-029 Wrap and write lockout: mem[63]=16'h00FF, pc_in=63 -> pc_next_out=0; prog_we=1 to address 63 during RUN -> a later fetch of 63 still returns 16'h00FF.
REQ-030 Halt: mem[2]=16'hF000, pc_in=2 -> one cycle with instr_out=16'hF000, valid_out=1 and state_out=10, then bubbles; start -> state_out=00.
REQ-031 Reset mid-run: assert rst_n=0 between edges during RUN -> outputs clear immediately and state_out=00; after release and start, mem[5] still reads 16'h1234.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch with program-load memory, IF/ID register and IDLE/RUN/HALT control.
module if_fetch_stage #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              hold_in,
  input  logic              flush_in,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc_next_out,
  output logic              valid_out,
  output logic [1:0]        state_out
);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_HALT = 2'b10} state_t;
  state_t            r_state, w_state_next;
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_instr, w_instr_next, w_fetch;
  logic [ADDR_W-1:0] r_pc_next, w_pc_next;
  logic              r_valid, w_valid_next, w_load, w_keep, w_is_halt;
  assign w_fetch   = r_mem[pc_in];
  assign w_is_halt = w_fetch[DATA_W-1 -: 4] == 4'hF;
  assign w_keep    = hold_in && !flush_in;
  assign w_load    = r_state == S_RUN && !flush_in && !hold_in;
  // Program memory has no reset so contents survive rst_n.
  always_ff @(posedge clk)
    if (prog_we && r_state == S_IDLE) r_mem[prog_addr] <= prog_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_instr   <= NOP_WORD;
      r_pc_next <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_instr   <= w_instr_next;
      r_pc_next <= w_pc_next;
      r_valid   <= w_valid_next;
    end
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  w_state_next = start ? S_RUN : S_IDLE;
      S_RUN:   w_state_next = (w_load && w_is_halt) ? S_HALT : S_RUN;
      S_HALT:  w_state_next = start ? S_IDLE : S_HALT;
      default: w_state_next = S_IDLE;
    endcase
    w_instr_next = w_keep ? r_instr   : w_load ? w_fetch             : NOP_WORD;
    w_pc_next    = w_keep ? r_pc_next : w_load ? pc_in + ADDR_W'(1)  : '0;
    w_valid_next = w_keep ? r_valid   : w_load;
  end
  assign instr_out   = r_instr;
  assign pc_next_out = r_pc_next;
  assign valid_out   = r_valid;
  assign state_out   = r_state;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: scoreboard bench; expected IF/ID values queued per driven cycle, popped after the edge.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  pc_in = '0, prog_addr = '0;
  logic        hold_in = 1'b0, flush_in = 1'b0, start = 1'b0, prog_we = 1'b0;
  logic [15:0] prog_data = '0;
  logic [15:0] instr_out;
  logic [5:0]  pc_next_out;
  logic        valid_out;
  logic [1:0]  state_out;
  int n_cmp = 0, n_bad = 0;
  typedef struct {string tag; logic [15:0] i; logic [5:0] p; logic v; logic [1:0] s;} exp_t;
  exp_t sb[$];
  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .hold_in(hold_in), .flush_in(flush_in),
    .start(start), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instr_out(instr_out), .pc_next_out(pc_next_out), .valid_out(valid_out), .state_out(state_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_out(input exp_t e);
    chk({e.tag, ".instr"}, 32'(instr_out), 32'(e.i));
    chk({e.tag, ".pc"}, 32'(pc_next_out), 32'(e.p));
    chk({e.tag, ".valid"}, 32'(valid_out), 32'(e.v));
    chk({e.tag, ".state"}, 32'(state_out), 32'(e.s));
  endtask
  task automatic step(input string tag, input logic [5:0] pc, input logic h, f, st, we,
                      input logic [5:0] wa, input logic [15:0] wd,
                      input logic [15:0] ei, input logic [5:0] ep, input logic ev, input logic [1:0] es);
    exp_t e;
    @(negedge clk);
    pc_in = pc; hold_in = h; flush_in = f; start = st; prog_we = we; prog_addr = wa; prog_data = wd;
    sb.push_back('{tag, ei, ep, ev, es});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_out(e);
  endtask
  initial begin
    #2;
    check_out('{"reset", 16'h0000, 6'd0, 1'b0, 2'b00});
    @(negedge clk);
    rst_n = 1'b1;
    //    tag        pc  h  f  st we addr  data      instr     pcn v  state
    step("ld5",      0, 0, 0, 0, 1, 5,  16'h1234, 16'h0000, 0, 0, 2'b00);
    step("ld1",      0, 0, 0, 0, 1, 1,  16'h0A0B, 16'h0000, 0, 0, 2'b00);
    step("ld63",     0, 0, 0, 0, 1, 63, 16'h00FF, 16'h0000, 0, 0, 2'b00);
    step("ld2",      0, 0, 0, 0, 1, 2,  16'hF000, 16'h0000, 0, 0, 2'b00);
    step("start",    5, 0, 0, 1, 0, 0,  16'h0000, 16'h0000, 0, 0, 2'b01);
    step("fetch5",   5, 0, 0, 1, 0, 0,  16'h0000, 16'h1234, 6, 1, 2'b01);
    step("fetch1",   1, 0, 0, 0, 0, 0,  16'h0000, 16'h0A0B, 2, 1, 2'b01);
    step("hold1",    1, 1, 0, 0, 0, 0,  16'h0000, 16'h0A0B, 2, 1, 2'b01);
    step("hold2",    1, 1, 0, 0, 0, 0,  16'h0000, 16'h0A0B, 2, 1, 2'b01);
    step("hold_pc5", 5, 1, 0, 0, 0, 0,  16'h0000, 16'h0A0B, 2, 1, 2'b01);
    step("hold_fl",  1, 1, 1, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 2'b01);
    step("fetch5b",  5, 0, 0, 0, 0, 0,  16'h0000, 16'h1234, 6, 1, 2'b01);
    step("fl_halt",  2, 0, 1, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 2'b01);
    step("hold_hlt", 2, 1, 0, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 2'b01);
    step("wrap_we",  63,0, 0, 0, 1, 63, 16'hBEEF, 16'h00FF, 0, 1, 2'b01);
    step("wrap_rd",  63,0, 0, 0, 0, 0,  16'h0000, 16'h00FF, 0, 1, 2'b01);
    step("halt",     2, 0, 0, 0, 0, 0,  16'h0000, 16'hF000, 3, 1, 2'b10);
    step("halt_bub", 5, 0, 0, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 2'b10);
    step("halt_we",  5, 0, 0, 0, 1, 5,  16'hDEAD, 16'h0000, 0, 0, 2'b10);
    step("to_idle",  5, 0, 0, 1, 0, 0,  16'h0000, 16'h0000, 0, 0, 2'b00);
    step("restart",  5, 0, 0, 1, 0, 0,  16'h0000, 16'h0000, 0, 0, 2'b01);
    step("fetch5c",  5, 0, 0, 0, 0, 0,  16'h0000, 16'h1234, 6, 1, 2'b01);
    step("fetch63",  63,0, 0, 0, 0, 0,  16'h0000, 16'h00FF, 0, 1, 2'b01);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_out('{"midrst", 16'h0000, 6'd0, 1'b0, 2'b00});
    @(negedge clk);
    rst_n = 1'b1;
    step("wait_idle",5, 0, 0, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 2'b00);
    step("restart2", 5, 0, 0, 1, 0, 0,  16'h0000, 16'h0000, 0, 0, 2'b01);
    step("retained", 5, 0, 0, 0, 0, 0,  16'h0000, 16'h1234, 6, 1, 2'b01);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
